tnoc_axi_read_arbiter: RTL and testbench
========================================

TNOC_AXI_READ_ARBITER -- requirements
Module: tnoc_axi_read_arbiter

Interface
REQ-001 Parameter REQUESTERS, default 2, number of upstream AXI read masters (>=2).
REQ-002 Parameter ID_WIDTH, default 4, upstream arid/rid width; downstream ID width MID_W = ID_WIDTH + $clog2(REQUESTERS).
REQ-003 Parameters ADDR_WIDTH = 32, DATA_WIDTH = 64; MAX_OUTSTANDING = 8, maximum downstream read bursts in flight.
REQ-004 Derived widths: AR_W = ID_WIDTH+ADDR_WIDTH+13; R_W = ID_WIDTH+DATA_WIDTH+3; M_AR_W and M_R_W use MID_W in place of ID_WIDTH.
REQ-005 Packing, MSB first: AR = {arid, araddr, arlen[7:0], arsize[2:0], arburst[1:0]}; R = {rid, rdata, rresp[1:0], rlast}.
REQ-006 i_clk  input  1  clock.
REQ-007 i_rst_n  input  1  reset; asynchronous, active-low.
REQ-008 i_arvalid  input  [REQUESTERS]  per-requester AR valid.
REQ-009 o_arready  output  [REQUESTERS]  per-requester AR ready.
REQ-010 i_ar  input  [REQUESTERS][AR_W]  per-requester AR payload.
REQ-011 o_arvalid  output  1  downstream AR valid, toward the slave read adapter.
REQ-012 i_arready  input  1  downstream AR ready.
REQ-013 o_ar  output  M_AR_W  downstream AR payload.
REQ-014 i_rvalid  input  1  downstream R valid.
REQ-015 o_rready  output  1  downstream R ready.
REQ-016 i_r  input  M_R_W  downstream R payload.
REQ-017 o_rvalid  output  [REQUESTERS]  per-requester R valid.
REQ-018 i_rready  input  [REQUESTERS]  per-requester R ready.
REQ-019 o_r  output  [REQUESTERS][R_W]  per-requester R payload.
REQ-020 o_outstanding  output  $clog2(MAX_OUTSTANDING+1)  bursts in flight.

Function
REQ-021 AR FSM states: IDLE and GRANT; grant index G and round-robin pointer P are registered.
REQ-022 IDLE -> GRANT when any i_arvalid is set and the limit is not reached; G = first requester asserting arvalid searching from P upward with wrap.
REQ-023 In GRANT: o_arvalid = i_arvalid[G]; o_ar = {G, i_ar[G]}; o_arready[G] = i_arready; all other o_arready = 0.
REQ-024 In IDLE: o_arvalid = 0; all o_arready = 0.
REQ-025 On a downstream AR handshake: GRANT -> IDLE; P = G+1, wrapping to 0 at REQUESTERS.
REQ-026 AR latency: minimum one cycle from i_arvalid to o_arvalid; one idle bubble between consecutive grants.
REQ-027 R routing is combinational, with index K = rid[MID_W-1:ID_WIDTH] of i_r.
REQ-028 o_rvalid[K] = i_rvalid, others 0; o_rready = i_rready[K].
REQ-029 Every o_r[k] = i_r with the index bits stripped.
REQ-030 Out-of-range K (K >= REQUESTERS): o_rready = 1, all o_rvalid = 0; the beat is dropped.
REQ-031 Outstanding count: +1 on downstream AR handshake; -1 on R handshake with rlast=1.
REQ-032 Simultaneous +1 and -1: count unchanged.
REQ-033 Decrement at count 0: count stays 0 (saturates).
REQ-034 Limit reached when count == MAX_OUTSTANDING: no IDLE -> GRANT transition; a grant already in GRANT completes.

Reset
REQ-035 Asynchronous assertion; state = IDLE, P = 0, G = 0, count = 0, o_arvalid = 0, o_arready = 0, o_outstanding = 0.
REQ-036 R outputs reflect inputs combinationally during reset.
REQ-037 Reset mid-burst discards all tracking; no recovery of in-flight bursts.

Configuration
REQ-038 Macro TNOC_AXI_READ_ARBITER_OUTSTANDING_LIMIT_EN defined: counter and limit per REQ-031..034.
REQ-039 Macro undefined: no counter; o_outstanding tied 0; grants never blocked by the limit.

Verification
REQ-040 Requesters 0 and 1 hold arvalid continuously, i_arready=1 -> grants alternate 0,1,0,1; o_ar arid MSB matches the requester; one bubble cycle between grants.
REQ-041 i_arready held 0 for 5 cycles in GRANT -> o_arvalid and o_ar stable; G unchanged; other requesters see arready=0.
REQ-042 i_r rid=5'b1_0011, rlast=1, i_rready[1]=0 then 1 -> o_rvalid[1]=1, o_r[1] rid=4'h3, o_rready follows i_rready[1].
REQ-043 Limit on, 8 AR handshakes without R -> o_outstanding=8, 9th request stays ungranted; one rlast beat -> count 7, grant next cycle.
REQ-044 AR handshake and rlast handshake in the same cycle at count 3 -> count stays 3.
REQ-045 i_rst_n asserted in GRANT with count 5 -> o_arvalid=0, o_outstanding=0 immediately; first grant after release goes to requester 0.

Source files
------------

// File: rtl/tnoc_axi_read_arbiter.sv
// Round-robin arbiter merging REQUESTERS AXI read masters onto one downstream read port.
// Define TNOC_AXI_READ_ARBITER_OUTSTANDING_LIMIT_EN to track bursts in flight and stall grants at MAX_OUTSTANDING.
module tnoc_axi_read_arbiter #(
   parameter int REQUESTERS      = 2,
   parameter int ID_WIDTH        = 4,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 64,
   parameter int MAX_OUTSTANDING = 8,
   localparam int IDX_W  = $clog2(REQUESTERS),
   localparam int MID_W  = ID_WIDTH + IDX_W,
   localparam int AR_W   = ID_WIDTH + ADDR_WIDTH + 13,
   localparam int R_W    = ID_WIDTH + DATA_WIDTH + 3,
   localparam int M_AR_W = MID_W + ADDR_WIDTH + 13,
   localparam int M_R_W  = MID_W + DATA_WIDTH + 3,
   localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                               i_clk,
   input  logic                               i_rst_n,
   input  logic [REQUESTERS-1:0]              i_arvalid,
   output logic [REQUESTERS-1:0]              o_arready,
   input  logic [REQUESTERS-1:0][AR_W-1:0]    i_ar,
   output logic                               o_arvalid,
   input  logic                               i_arready,
   output logic [M_AR_W-1:0]                  o_ar,
   input  logic                               i_rvalid,
   output logic                               o_rready,
   input  logic [M_R_W-1:0]                   i_r,
   output logic [REQUESTERS-1:0]              o_rvalid,
   input  logic [REQUESTERS-1:0]              i_rready,
   output logic [REQUESTERS-1:0][R_W-1:0]     o_r,
   output logic [CNT_W-1:0]                   o_outstanding
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] g_q, g_d, p_q, p_d;
   logic             limit_hit;

   // First requester with arvalid set, searching upward from p with wrap.
   function automatic logic [IDX_W-1:0] pick(input logic [REQUESTERS-1:0] v,
                                             input logic [IDX_W-1:0] p);
      logic [IDX_W-1:0] r;
      logic             found;
      int               idx;
      r     = p;
      found = 1'b0;
      for (int i = 0; i < REQUESTERS; i++) begin
         idx = (int'(p) + i) % REQUESTERS;
         if (!found && v[idx]) begin
            r     = IDX_W'(idx);
            found = 1'b1;
         end
      end
      return r;
   endfunction

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         g_q     <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         p_q     <= p_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      g_d       = g_q;
      p_d       = p_q;
      o_arvalid = 1'b0;
      o_arready = '0;
      o_ar      = {g_q, i_ar[g_q]};
      case (state_q)
         IDLE: begin
            if (|i_arvalid && !limit_hit) begin
               state_d = GRANT;
               g_d     = pick(i_arvalid, p_q);
            end
         end
         GRANT: begin
            o_arvalid      = i_arvalid[g_q];
            o_arready[g_q] = i_arready;
            if (i_arvalid[g_q] && i_arready) begin
               state_d = IDLE;
               p_d     = (g_q == IDX_W'(REQUESTERS - 1)) ? '0 : g_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef TNOC_AXI_READ_ARBITER_OUTSTANDING_LIMIT_EN
   logic [CNT_W-1:0] cnt_q;
   logic             ar_hs, r_last_hs;

   assign ar_hs     = (state_q == GRANT) && i_arvalid[g_q] && i_arready;
   assign r_last_hs = i_rvalid && o_rready && i_r[0];

   // Concurrent issue and retire cancel; retire at zero saturates.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         cnt_q <= '0;
      else if (ar_hs && !r_last_hs)
         cnt_q <= cnt_q + 1'b1;
      else if (!ar_hs && r_last_hs && cnt_q != '0)
         cnt_q <= cnt_q - 1'b1;
   end

   assign limit_hit     = (cnt_q == CNT_W'(MAX_OUTSTANDING));
   assign o_outstanding = cnt_q;
`else
   assign limit_hit     = 1'b0;
   assign o_outstanding = '0;
`endif

   // R path is purely combinational: top ID bits select the requester.
   logic [IDX_W-1:0] r_idx;
   logic             r_in_range;

   assign r_idx      = i_r[M_R_W-1 -: IDX_W];
   assign r_in_range = (int'(r_idx) < REQUESTERS);
   assign o_rready   = r_in_range ? i_rready[r_idx] : 1'b1;

   for (genvar k = 0; k < REQUESTERS; k++) begin : g_rlane
      assign o_rvalid[k] = i_rvalid && r_in_range && (r_idx == IDX_W'(k));
      assign o_r[k]      = i_r[R_W-1:0];
   end

endmodule

// File: tb/tb_tnoc_axi_read_arbiter.sv
// Directed bench for tnoc_axi_read_arbiter: R routing table plus AR arbitration/limit sequences.
module tb_tnoc_axi_read_arbiter;

   localparam int RQ     = 2;
   localparam int AR_W   = 49;
   localparam int R_W    = 71;
   localparam int M_AR_W = 50;
   localparam int M_R_W  = 72;
   localparam int CW     = 4;
`ifdef TNOC_AXI_READ_ARBITER_OUTSTANDING_LIMIT_EN
   localparam bit LIM = 1'b1;
`else
   localparam bit LIM = 1'b0;
`endif

   logic                      i_clk = 1'b0;
   logic                      i_rst_n;
   logic [RQ-1:0]             i_arvalid;
   logic [RQ-1:0]             o_arready;
   logic [RQ-1:0][AR_W-1:0]   i_ar;
   logic                      o_arvalid;
   logic                      i_arready;
   logic [M_AR_W-1:0]         o_ar;
   logic                      i_rvalid;
   logic                      o_rready;
   logic [M_R_W-1:0]          i_r;
   logic [RQ-1:0]             o_rvalid;
   logic [RQ-1:0]             i_rready;
   logic [RQ-1:0][R_W-1:0]    o_r;
   logic [CW-1:0]             o_outstanding;

   tnoc_axi_read_arbiter dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_arvalid(i_arvalid), .o_arready(o_arready), .i_ar(i_ar),
      .o_arvalid(o_arvalid), .i_arready(i_arready), .o_ar(o_ar),
      .i_rvalid(i_rvalid), .o_rready(o_rready), .i_r(i_r),
      .o_rvalid(o_rvalid), .i_rready(i_rready), .o_r(o_r),
      .o_outstanding(o_outstanding)
   );

   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [4:0] rid;
      logic       v;
      logic [1:0] rr;
      logic       last;
      logic [1:0] ev;
      logic       er;
   } rvec_t;

   rvec_t tv[6];

   logic [AR_W-1:0]   ar0, ar1;
   logic [M_AR_W-1:0] exp_ar;
   logic [63:0]       rdata;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive_r(input logic [4:0] rid, input logic v, input logic last);
      i_rvalid = v;
      i_r      = {rid, 64'hC0DE_0000_0000_0001, 2'b00, last};
   endtask

   task automatic do_reset();
      i_rst_n   = 1'b0;
      i_arvalid = '0;
      i_arready = 1'b0;
      i_rvalid  = 1'b0;
      i_rready  = '0;
      i_r       = '0;
      repeat (2) @(posedge i_clk);
      #1 i_rst_n = 1'b1;
   endtask

   initial begin
      ar0  = {4'h2, 32'h1000_0040, 8'd3, 3'd3, 2'b01};
      ar1  = {4'h7, 32'h2000_0080, 8'd0, 3'd3, 2'b01};
      i_ar = {ar1, ar0};

      tv[0] = '{5'b1_0011, 1'b1, 2'b00, 1'b1, 2'b10, 1'b0};
      tv[1] = '{5'b1_0011, 1'b1, 2'b10, 1'b1, 2'b10, 1'b1};
      tv[2] = '{5'b0_0101, 1'b1, 2'b01, 1'b0, 2'b01, 1'b1};
      tv[3] = '{5'b0_0101, 1'b1, 2'b10, 1'b1, 2'b01, 1'b0};
      tv[4] = '{5'b1_1111, 1'b0, 2'b10, 1'b0, 2'b00, 1'b1};
      tv[5] = '{5'b0_0000, 1'b0, 2'b00, 1'b1, 2'b00, 1'b0};

      // Reset state
      do_reset();
      #1;
      chk("rst_arvalid", o_arvalid, 1'b0);
      chk("rst_arready", o_arready, 2'b00);
      chk("rst_outstanding", o_outstanding, 4'd0);

      // R routing table
      for (int i = 0; i < 6; i++) begin
         rdata    = {32'hA5A5_0000, 32'(i)};
         i_rvalid = tv[i].v;
         i_rready = tv[i].rr;
         i_r      = {tv[i].rid, rdata, 2'b01, tv[i].last};
         #1;
         chk($sformatf("rvalid[%0d]", i), o_rvalid, tv[i].ev);
         chk($sformatf("rready[%0d]", i), o_rready, tv[i].er);
         chk($sformatf("r0[%0d]", i), o_r[0], {tv[i].rid[3:0], rdata, 2'b01, tv[i].last});
         chk($sformatf("r1[%0d]", i), o_r[1], {tv[i].rid[3:0], rdata, 2'b01, tv[i].last});
      end

      // Alternating grants with a bubble between them
      do_reset();
      i_arvalid = 2'b11;
      i_arready = 1'b1;
      #1;
      chk("lat_first", o_arvalid, 1'b0);
      for (int n = 0; n < 4; n++) begin
         step();
         exp_ar = (n % 2 == 1) ? {1'b1, ar1} : {1'b0, ar0};
         chk($sformatf("alt_valid%0d", n), o_arvalid, 1'b1);
         chk($sformatf("alt_ar%0d", n), o_ar, exp_ar);
         chk($sformatf("alt_ready%0d", n), o_arready, (n % 2 == 1) ? 2'b10 : 2'b01);
         step();
         chk($sformatf("bubble%0d", n), {o_arvalid, o_arready}, 3'b000);
      end

      // Downstream stall holds the grant
      do_reset();
      i_arvalid = 2'b01;
      step();
      i_arvalid = 2'b11;
      #1;
      for (int n = 0; n < 5; n++) begin
         chk($sformatf("stall_valid%0d", n), o_arvalid, 1'b1);
         chk($sformatf("stall_ar%0d", n), o_ar, {1'b0, ar0});
         chk($sformatf("stall_ready%0d", n), o_arready, 2'b00);
         step();
      end
      i_arready = 1'b1;
      #1;
      chk("stall_release", o_arready, 2'b01);
      step();
      chk("stall_idle", o_arvalid, 1'b0);
      step();
      chk("stall_next", o_ar, {1'b1, ar1});

      // Outstanding limit: 8 bursts, 9th waits until one retires
      do_reset();
      i_arvalid = 2'b01;
      i_arready = 1'b1;
      i_rready  = 2'b01;
      repeat (16) step();
      chk("lim_cnt8", o_outstanding, LIM ? 4'd8 : 4'd0);
      step();
      chk("lim_block", o_arvalid, LIM ? 1'b0 : 1'b1);
      drive_r(5'b0_0001, 1'b1, 1'b1);
      #1;
      chk("lim_rvalid", o_rvalid, 2'b01);
      step();
      drive_r(5'b0_0001, 1'b0, 1'b0);
      chk("lim_cnt7", o_outstanding, LIM ? 4'd7 : 4'd0);
      step();
      chk("lim_regrant", o_arvalid, 1'b1);

      // Retire at zero saturates, then one issue counts to 1
      do_reset();
      i_rready = 2'b01;
      drive_r(5'b0_0000, 1'b1, 1'b1);
      step();
      drive_r(5'b0_0000, 1'b0, 1'b0);
      chk("sat_zero", o_outstanding, 4'd0);
      i_arvalid = 2'b01;
      i_arready = 1'b1;
      repeat (2) step();
      chk("sat_inc", o_outstanding, LIM ? 4'd1 : 4'd0);

      // Concurrent issue and retire at count 3
      do_reset();
      i_arvalid = 2'b01;
      i_arready = 1'b1;
      i_rready  = 2'b01;
      repeat (6) step();
      chk("sim_cnt3", o_outstanding, LIM ? 4'd3 : 4'd0);
      step();
      chk("sim_grant", o_arvalid, 1'b1);
      drive_r(5'b0_0010, 1'b1, 1'b1);
      step();
      drive_r(5'b0_0010, 1'b0, 1'b0);
      chk("sim_hold3", o_outstanding, LIM ? 4'd3 : 4'd0);

      // Asynchronous reset in GRANT with bursts outstanding
      do_reset();
      i_arvalid = 2'b01;
      i_arready = 1'b1;
      repeat (10) step();
      i_arready = 1'b0;
      step();
      chk("pre_rst_valid", o_arvalid, 1'b1);
      chk("pre_rst_cnt", o_outstanding, LIM ? 4'd5 : 4'd0);
      #1 i_rst_n = 1'b0;
      drive_r(5'b1_0001, 1'b1, 1'b0);
      #1;
      chk("arst_valid", o_arvalid, 1'b0);
      chk("arst_ready", o_arready, 2'b00);
      chk("arst_cnt", o_outstanding, 4'd0);
      chk("arst_rvalid", o_rvalid, 2'b10);
      drive_r(5'b1_0001, 1'b0, 1'b0);
      i_arvalid = 2'b11;
      i_arready = 1'b1;
      #1 i_rst_n = 1'b1;
      step();
      chk("post_rst_grant", o_ar, {1'b0, ar0});
      chk("post_rst_valid", o_arvalid, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
